// File: rtl/alu_writeback_stage.sv
// Registered writeback stage after the 8-bit adder: one-entry output buffer,
// accumulator, {Z,N,V,C} status register, branch-condition select and overflow-event counter.
module alu_writeback_stage #(
  parameter int unsigned OVF_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           in_result,
  input  logic [7:0]           in_flags,
  input  logic                 in_wr_acc,
  input  logic [3:0]           in_flag_mask,
  input  logic                 sr_clr,
  input  logic [2:0]           cond_sel,
  output logic                 cond_taken,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           out_result,
  output logic [3:0]           out_flags,
  output logic [7:0]           acc,
  output logic [3:0]           sr,
  output logic [OVF_CNT_W-1:0] ovf_cnt
);

  localparam int unsigned FLAG_W = 4;
  localparam int unsigned C_BIT  = 0;
  localparam int unsigned V_BIT  = 1;
  localparam int unsigned N_BIT  = 2;
  localparam int unsigned Z_BIT  = 3;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t              state;
  state_t              state_nxt;
  logic                accept;
  logic [FLAG_W-1:0]   new_flags;
  logic                unused_flags;

  assign new_flags    = in_flags[FLAG_W-1:0];
  assign unused_flags = ^in_flags[7:FLAG_W];

  // Buffer may take a new entry when empty or when its current entry leaves this cycle
  assign in_ready  = (state == EMPTY) || out_ready;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (accept) state_nxt = FULL;
      FULL:    if (out_ready && !accept) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_result <= '0;
      out_flags  <= '0;
      acc        <= '0;
    end else if (accept) begin
      out_result <= in_result;
      out_flags  <= new_flags;
      if (in_wr_acc) acc <= in_result;
    end
  end

  // Clear wins over a same-cycle masked flag update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else if (sr_clr) begin
      sr <= '0;
    end else if (accept) begin
      sr <= (sr & ~in_flag_mask) | (new_flags & in_flag_mask);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt <= '0;
    end else if (accept && new_flags[V_BIT] && (ovf_cnt != {OVF_CNT_W{1'b1}})) begin
      ovf_cnt <= ovf_cnt + OVF_CNT_W'(1);
    end
  end

  // Branch conditions look only at the committed SR
  always_comb begin
    cond_taken = 1'b1;
    case (cond_sel)
      3'd0:    cond_taken = 1'b1;
      3'd1:    cond_taken = sr[Z_BIT];
      3'd2:    cond_taken = !sr[Z_BIT];
      3'd3:    cond_taken = sr[C_BIT];
      3'd4:    cond_taken = !sr[C_BIT];
      3'd5:    cond_taken = sr[N_BIT];
      3'd6:    cond_taken = sr[V_BIT];
      3'd7:    cond_taken = sr[N_BIT] ^ sr[V_BIT];
      default: cond_taken = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Self-checking bench for alu_writeback_stage: directed vector table, hand-written
// backpressure/saturation/reset sequences and randomized traffic against a reference model.
module tb_alu_writeback_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_result;
  logic [7:0] in_flags;
  logic       in_wr_acc;
  logic [3:0] in_flag_mask;
  logic       sr_clr;
  logic [2:0] cond_sel;
  logic       cond_taken;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_result;
  logic [3:0] out_flags;
  logic [7:0] acc;
  logic [3:0] sr;
  logic [7:0] ovf_cnt;

  int checks = 0;
  int errors = 0;

  alu_writeback_stage #(.OVF_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_flags(in_flags), .in_wr_acc(in_wr_acc),
    .in_flag_mask(in_flag_mask), .sr_clr(sr_clr), .cond_sel(cond_sel),
    .cond_taken(cond_taken), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags), .acc(acc), .sr(sr),
    .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  // Reference model state: a one-slot output buffer plus architectural registers
  bit       m_full;
  int       m_res;
  int       m_flg;
  int       m_acc;
  bit [3:0] m_sr;
  int       m_cnt;
  localparam int CNT_MAX = 255;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_cond(input int sel, input bit [3:0] s);
    bit c, v, n, z;
    {z, n, v, c} = s;
    case (sel)
      0: return 1'b1;
      1: return z;
      2: return !z;
      3: return c;
      4: return !c;
      5: return n;
      6: return v;
      default: return n != v;
    endcase
  endfunction

  task automatic model_reset();
    m_full = 0; m_res = 0; m_flg = 0; m_acc = 0; m_sr = '0; m_cnt = 0;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_result = '0; in_flags = '0; in_wr_acc = 0;
    in_flag_mask = '0; sr_clr = 0; cond_sel = '0; out_ready = 1;
  endtask

  // One clock: check everything against the model mid-cycle, then advance the model
  task automatic cycle();
    bit take;
    @(negedge clk);
    chk("in_ready", 32'(in_ready), 32'(!m_full || out_ready));
    chk("cond_taken", 32'(cond_taken), 32'(m_cond(int'(cond_sel), m_sr)));
    chk("out_valid", 32'(out_valid), 32'(m_full));
    if (m_full) begin
      chk("out_result", 32'(out_result), 32'(m_res));
      chk("out_flags", 32'(out_flags), 32'(m_flg));
    end
    chk("acc", 32'(acc), 32'(m_acc));
    chk("sr", 32'(sr), 32'(m_sr));
    chk("ovf_cnt", 32'(ovf_cnt), 32'(m_cnt));
    take = in_valid && (!m_full || out_ready);
    @(posedge clk);
    #1;
    if (take) begin
      m_full = 1;
      m_res  = int'(in_result);
      m_flg  = int'(in_flags) % 16;
      if (in_wr_acc) m_acc = int'(in_result);
      for (int i = 0; i < 4; i++) if (in_flag_mask[i]) m_sr[i] = in_flags[i];
      if (in_flags[1] && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    end else if (out_ready) begin
      m_full = 0;
    end
    if (sr_clr) m_sr = '0;
  endtask

  typedef struct {
    bit       v;
    bit [7:0] res;
    bit [7:0] flg;
    bit       wr;
    bit [3:0] mask;
    bit       clr;
    bit [2:0] sel;
    bit [7:0] e_acc;
    bit [3:0] e_sr;
    bit [7:0] e_cnt;
    bit       e_ov;
    bit [7:0] e_or;
    bit [3:0] e_of;
    bit       e_cond;
  } vec_t;

  vec_t vecs[8];

  initial begin
    //            v  res    flg    wr mask  clr sel  acc    sr    cnt ov  out    of    cond
    vecs[0] = '{1, 8'h80, 8'h06, 1, 4'hF, 0, 3'd7, 8'h80, 4'h6, 8'd1, 1, 8'h80, 4'h6, 0};
    vecs[1] = '{0, 8'h00, 8'h00, 0, 4'h0, 0, 3'd5, 8'h80, 4'h6, 8'd1, 0, 8'h80, 4'h6, 1};
    vecs[2] = '{1, 8'h00, 8'h0B, 1, 4'h1, 0, 3'd3, 8'h00, 4'h7, 8'd2, 1, 8'h00, 4'hB, 1};
    vecs[3] = '{0, 8'h00, 8'h00, 0, 4'h0, 0, 3'd1, 8'h00, 4'h7, 8'd2, 0, 8'h00, 4'hB, 0};
    vecs[4] = '{1, 8'h5A, 8'h0F, 1, 4'hF, 1, 3'd0, 8'h5A, 4'h0, 8'd3, 1, 8'h5A, 4'hF, 1};
    vecs[5] = '{1, 8'h33, 8'hF4, 0, 4'hF, 0, 3'd5, 8'h5A, 4'h4, 8'd3, 1, 8'h33, 4'h4, 1};
    vecs[6] = '{0, 8'h00, 8'h00, 0, 4'h0, 0, 3'd7, 8'h5A, 4'h4, 8'd3, 0, 8'h33, 4'h4, 1};
    vecs[7] = '{0, 8'h00, 8'h00, 0, 4'h0, 0, 3'd2, 8'h5A, 4'h4, 8'd3, 0, 8'h33, 4'h4, 1};

    // Reset held with random inputs
    rst_n = 0;
    in_valid = 1; in_result = 8'($urandom); in_flags = 8'($urandom); in_wr_acc = 1;
    in_flag_mask = 4'hF; sr_clr = 0; cond_sel = 3'd1; out_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst out_result", 32'(out_result), 0);
    chk("rst out_flags", 32'(out_flags), 0);
    chk("rst acc", 32'(acc), 0);
    chk("rst sr", 32'(sr), 0);
    chk("rst ovf_cnt", 32'(ovf_cnt), 0);
    chk("rst in_ready", 32'(in_ready), 1);
    model_reset();
    idle_inputs();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    repeat (3) cycle();

    // Directed vector table
    for (int i = 0; i < 8; i++) begin
      in_valid = vecs[i].v; in_result = vecs[i].res; in_flags = vecs[i].flg;
      in_wr_acc = vecs[i].wr; in_flag_mask = vecs[i].mask; sr_clr = vecs[i].clr;
      cond_sel = vecs[i].sel; out_ready = 1;
      cycle();
      chk($sformatf("vec%0d acc", i), 32'(acc), 32'(vecs[i].e_acc));
      chk($sformatf("vec%0d sr", i), 32'(sr), 32'(vecs[i].e_sr));
      chk($sformatf("vec%0d ovf_cnt", i), 32'(ovf_cnt), 32'(vecs[i].e_cnt));
      chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      chk($sformatf("vec%0d out_result", i), 32'(out_result), 32'(vecs[i].e_or));
      chk($sformatf("vec%0d out_flags", i), 32'(out_flags), 32'(vecs[i].e_of));
      chk($sformatf("vec%0d cond_taken", i), 32'(cond_taken), 32'(vecs[i].e_cond));
    end

    // Backpressure: 0x22 must wait upstream until downstream drains 0x11
    idle_inputs();
    out_ready = 0; in_valid = 1; in_result = 8'h11; in_wr_acc = 1;
    cycle();
    chk("bp first out", 32'(out_result), 32'h11);
    in_result = 8'h22;
    #1;
    chk("bp in_ready low", 32'(in_ready), 0);
    repeat (2) cycle();
    chk("bp hold out", 32'(out_result), 32'h11);
    chk("bp hold acc", 32'(acc), 32'h11);
    out_ready = 1;
    #1;
    chk("bp in_ready high", 32'(in_ready), 1);
    cycle();
    chk("bp second out", 32'(out_result), 32'h22);
    chk("bp second acc", 32'(acc), 32'h22);
    chk("bp second valid", 32'(out_valid), 1);
    in_valid = 0;
    cycle();
    chk("bp drained", 32'(out_valid), 0);

    // Overflow counter saturation
    idle_inputs();
    in_valid = 1; in_flags = 8'h02;
    repeat (260) cycle();
    chk("sat cnt", 32'(ovf_cnt), 32'd255);
    in_flags = 8'h0D;
    repeat (3) cycle();
    chk("sat hold", 32'(ovf_cnt), 32'd255);

    // Reset while FULL under backpressure drops out_valid at once
    idle_inputs();
    out_ready = 0; in_valid = 1; in_result = 8'hC3; in_wr_acc = 1;
    cycle();
    chk("pre-rst valid", 32'(out_valid), 1);
    rst_n = 0;
    #1;
    chk("async rst valid", 32'(out_valid), 0);
    chk("async rst acc", 32'(acc), 0);
    chk("async rst cnt", 32'(ovf_cnt), 0);
    model_reset();
    idle_inputs();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    // Randomized traffic against the model
    for (int n = 0; n < 2000; n++) begin
      in_valid     = 1'($urandom_range(0, 3) != 0);
      in_result    = 8'($urandom);
      in_flags     = 8'($urandom);
      in_wr_acc    = 1'($urandom);
      in_flag_mask = 4'($urandom);
      sr_clr       = 1'($urandom_range(0, 7) == 0);
      cond_sel     = 3'($urandom);
      out_ready    = 1'($urandom_range(0, 2) != 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
